// File: rtl/uart_axis_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_axis_pkg
//  Description : Shared types and helpers for the UART RX -> AXI-Stream
//                bridge: the receive FSM state type, parity mode
//                constants and the baud divider calculation.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_axis_pkg;

  // Receive FSM states with an explicit 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Parity modes, resolved from the string parameter at elaboration.
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Clocks per bit; integer divide truncates toward zero.
  function automatic int calc_baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_frame
//  Description : UART frame receiver. Synchronises rx, finds the start bit,
//                samples every bit at its centre, checks parity and stop
//                bit, and reports one result pulse per completed frame.
//  Revision    : 1.0 - initial release
//  Ports
//    clk, rst          clock, asynchronous active-high reset
//    rx_i              raw serial line (idle high, asynchronous)
//    byte_o            received data, valid while byte_valid_o is high
//    byte_valid_o      1-clk pulse: good frame received
//    parity_err_o      1-clk pulse: frame dropped on parity mismatch
//    frame_err_o       1-clk pulse: frame dropped, stop bit was 0
//    start_det_o       start-bit edge seen in IDLE (combinational)
//    idle_o            FSM is in IDLE
// ============================================================================
module uart_rx_frame
  import uart_axis_pkg::*;
#(
  parameter int BAUD_DIV  = 16,
  parameter int DATA_BITS = 8,
  parameter int PAR_MODE  = PAR_EVEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] byte_o,
  output logic                 byte_valid_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 start_det_o,
  output logic                 idle_o
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] c_HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] c_FULL_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] c_BITS_LAST = BIT_W'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 w_rx;
  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 byte_valid_q, byte_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 w_start;
  logic                 w_bit_done;

  assign w_rx = sync_q[1];

  always_comb begin
    state_d      = state_q;
    baud_cnt_d   = baud_cnt_q + 1'b1;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    byte_valid_d = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    w_start      = 1'b0;
    w_bit_done   = (baud_cnt_q == c_FULL_LAST);
    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        if (!w_rx) begin
          state_d = ST_START;
          w_start = 1'b1;
        end
      end
      ST_START: begin
        // Half-bit check rejects glitches and aligns later samples to mid-bit.
        if (baud_cnt_q == c_HALF_LAST) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          par_bad_d  = 1'b0;
          state_d    = w_rx ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_done) begin
          baud_cnt_d = '0;
          shift_d    = {w_rx, shift_q[DATA_BITS-1:1]};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == c_BITS_LAST) begin
            state_d = (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_done) begin
          baud_cnt_d = '0;
          par_bad_d  = ((^{shift_q, w_rx}) != (PAR_MODE == PAR_ODD));
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leave at mid-stop so the next start edge is caught without slip.
        if (w_bit_done) begin
          baud_cnt_d = '0;
          state_d    = ST_IDLE;
          if (!w_rx) begin
            frame_err_d = 1'b1;
          end else if (par_bad_q) begin
            parity_err_d = 1'b1;
          end else begin
            byte_valid_d = 1'b1;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        baud_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= 2'b11;
      state_q      <= ST_IDLE;
      baud_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      byte_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], rx_i};
      state_q      <= state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      byte_valid_q <= byte_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = byte_valid_q;
  assign parity_err_o = parity_err_q;
  assign frame_err_o  = frame_err_q;
  assign start_det_o  = w_start;
  assign idle_o       = (state_q == ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_rx_axis_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_axis_bridge
//  Description : UART receiver feeding a first-word-fall-through FIFO that
//                is presented as an AXI-Stream master.
//  Revision    : 1.0 - initial release
//  Build macro : UART_RX_IDLE_TLAST_EN - hold the newest byte in a staging
//                register and mark it tlast once the line has been idle
//                for IDLE_BITS bit-times. Undefined: tlast tied to 0.
//  Ports
//    clk, rst          clock, asynchronous active-high reset
//    rx                UART serial line (idle high)
//    m_axis_*          AXI-Stream master (tdata/tvalid/tready/tlast)
//    parity_err        1-clk pulse: frame dropped on parity mismatch
//    frame_err         1-clk pulse: frame dropped, stop bit was 0
//    overrun_err       1-clk pulse: byte dropped, FIFO full
//    fifo_level        current FIFO occupancy
// ============================================================================
module uart_rx_axis_bridge
  import uart_axis_pkg::*;
#(
  parameter int    CLK_FREQ   = 50_000_000,
  parameter int    BAUD       = 115_200,
  parameter int    DATA_BITS  = 8,
  parameter string PARITY     = "even",
  parameter int    FIFO_DEPTH = 16,
  parameter int    IDLE_BITS  = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  output logic [DATA_BITS-1:0]        m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        overrun_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
  localparam int PAR_MODE = (PARITY == "none") ? PAR_NONE :
                            (PARITY == "odd")  ? PAR_ODD  : PAR_EVEN;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] c_DEPTH = (AW + 1)'(FIFO_DEPTH);

  logic [DATA_BITS-1:0] w_byte;
  logic                 w_byte_valid;
  logic                 w_start_det;
  logic                 w_idle;

  uart_rx_frame #(
    .BAUD_DIV  (BAUD_DIV),
    .DATA_BITS (DATA_BITS),
    .PAR_MODE  (PAR_MODE)
  ) u_frame (
    .clk          (clk),
    .rst          (rst),
    .rx_i         (rx),
    .byte_o       (w_byte),
    .byte_valid_o (w_byte_valid),
    .parity_err_o (parity_err),
    .frame_err_o  (frame_err),
    .start_det_o  (w_start_det),
    .idle_o       (w_idle)
  );

  logic                 w_push;
  logic [DATA_BITS-1:0] w_push_data;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_wr_en;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q;
  logic                 overrun_q;

  assign m_axis_tvalid = (count_q != '0);
  // Masked so tdata reads 0 out of reset and whenever the FIFO is empty.
  assign m_axis_tdata  = m_axis_tvalid ? mem_q[rd_ptr_q] : '0;
  assign w_pop         = m_axis_tvalid && m_axis_tready;
  assign w_full        = (count_q == c_DEPTH);
  // A same-cycle pop frees the head slot, so a push into a full FIFO is safe.
  assign w_wr_en       = w_push && (!w_full || w_pop);

`ifdef UART_RX_IDLE_TLAST_EN
  localparam int IDLE_CLKS = IDLE_BITS * BAUD_DIV;
  localparam int IW        = $clog2(IDLE_CLKS);
  localparam logic [IW-1:0] c_IDLE_LAST = IW'(IDLE_CLKS - 1);

  logic                 stage_valid_q;
  logic [DATA_BITS-1:0] stage_data_q;
  logic [IW-1:0]        idle_cnt_q;
  logic                 last_mem_q [FIFO_DEPTH];
  logic                 w_timeout;

  // Staged byte becomes end-of-burst after an uninterrupted idle stretch.
  assign w_timeout   = stage_valid_q && w_idle && !w_start_det && !w_byte_valid &&
                       (idle_cnt_q == c_IDLE_LAST);
  assign w_push      = (w_byte_valid && stage_valid_q) || w_timeout;
  assign w_push_data = stage_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      idle_cnt_q    <= '0;
    end else begin
      if (w_byte_valid) begin
        stage_valid_q <= 1'b1;
        stage_data_q  <= w_byte;
      end else if (w_timeout) begin
        stage_valid_q <= 1'b0;
      end
      if (w_byte_valid || w_start_det) begin
        idle_cnt_q <= '0;
      end else if (stage_valid_q && w_idle && !w_timeout) begin
        idle_cnt_q <= idle_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      last_mem_q[wr_ptr_q] <= w_timeout;
    end
  end

  assign m_axis_tlast = m_axis_tvalid && last_mem_q[rd_ptr_q];
`else
  assign w_push       = w_byte_valid;
  assign w_push_data  = w_byte;
  assign m_axis_tlast = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= w_push && w_full && !w_pop;
      if (w_wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({w_wr_en, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[wr_ptr_q] <= w_push_data;
    end
  end

  assign overrun_err = overrun_q;
  assign fifo_level  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_axis_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_axis_bridge
//  Description : Self-checking bench for uart_rx_axis_bridge. Frames are
//                driven bit by bit; a queue model predicts delivered bytes,
//                error pulse counts and FIFO occupancy from the frame rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_axis_bridge;

  localparam int DIV       = 16;
  localparam int DEPTH     = 16;
  localparam int IDLE_BITS = 10;
`ifdef UART_RX_IDLE_TLAST_EN
  localparam bit TLAST_ON = 1'b1;
`else
  localparam bit TLAST_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       m_axis_tready = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tlast;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic [4:0] fifo_level;

  always #5 clk = ~clk;

  uart_rx_axis_bridge #(
    .CLK_FREQ   (1_600_000),
    .BAUD       (100_000),
    .DATA_BITS  (8),
    .PARITY     ("even"),
    .FIFO_DEPTH (DEPTH),
    .IDLE_BITS  (IDLE_BITS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .parity_err    (parity_err),
    .frame_err     (frame_err),
    .overrun_err   (overrun_err),
    .fifo_level    (fifo_level)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] hist[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  model_level = 0;
  bit  pending  = 1'b0;
  int  exp_perr = 0, exp_ferr = 0, exp_ovr = 0;
  int  act_perr = 0, act_ferr = 0, act_ovr = 0;
  int  n_pops = 0;
  bit  rand_ready = 1'b0;
  logic [7:0] last_pop_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (DIV) tick();
  endtask

  task automatic idle(input int bits);
    rx = 1'b1;
    repeat (bits * DIV) tick();
    if (bits >= IDLE_BITS) pending = 1'b0;
  endtask

  // One frame: start, 8 data LSB first, even parity, stop. The model is
  // updated before the stop bit, ahead of the earliest possible delivery.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    exp_t e;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit((^d) ^ bad_par);
    if (bad_stop) begin
      exp_ferr++;
    end else if (bad_par) begin
      exp_perr++;
    end else begin
      if (TLAST_ON && pending && exp_q.size() > 0) begin
        e = exp_q[exp_q.size() - 1];
        e.last = 1'b0;
        exp_q[exp_q.size() - 1] = e;
      end
      if (model_level == DEPTH) begin
        exp_ovr++;
        pending = 1'b0;
      end else begin
        e.data = d;
        e.last = TLAST_ON;
        exp_q.push_back(e);
        model_level++;
        pending = 1'b1;
      end
    end
    drive_bit(!bad_stop);
    rx = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      tick();
      n++;
    end
    repeat (4) tick();
    check({name, "_pending_bytes"}, exp_q.size(), 0);
    check({name, "_tvalid_idle"}, m_axis_tvalid, 1'b0);
    check({name, "_level_idle"}, fifo_level, 0);
  endtask

  task automatic check_errs(input string name);
    check({name, "_parity_err_cnt"}, act_perr, exp_perr);
    check({name, "_frame_err_cnt"}, act_ferr, exp_ferr);
    check({name, "_overrun_err_cnt"}, act_ovr, exp_ovr);
  endtask

  // Compare process: pulses, every accepted beat, and hold stability.
  initial begin : g_compare
    exp_t e;
    logic prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (parity_err)  act_perr++;
        if (frame_err)   act_ferr++;
        if (overrun_err) act_ovr++;
        if (prev_stall) begin
          check("hold_tvalid", m_axis_tvalid, 1'b1);
          check("hold_tdata", m_axis_tdata, prev_data);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          n_pops++;
          last_pop_data = m_axis_tdata;
          hist.push_back({m_axis_tlast, m_axis_tdata});
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_unexpected: got tdata 0x%02h, expected no beat", m_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            model_level--;
            check("beat_tdata", m_axis_tdata, e.data);
            check("beat_tlast", m_axis_tlast, e.last);
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
      end
    end
  end

  initial begin : g_watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : g_main
    int p0;
    // Reset state.
    repeat (5) tick();
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tdata", m_axis_tdata, 8'h00);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_errs", {parity_err, frame_err, overrun_err}, 3'b000);
    check("rst_level", fifo_level, 0);
    rst = 1'b0;
    idle(2);

    // 1: single good byte.
    m_axis_tready = 1'b1;
    p0 = n_pops;
    send_frame(8'hA5, 1'b0, 1'b0);
    idle(12);
    drain("t1");
    check("t1_beats", n_pops - p0, 1);
    check("t1_data", last_pop_data, 8'hA5);
    check_errs("t1");

    // 2: parity error drops the frame.
    p0 = n_pops;
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(2);
    check("t2_level", fifo_level, 0);
    check("t2_beats", n_pops - p0, 0);
    check("t2_parity_err_cnt", act_perr, 1);

    // 3: framing error then a good byte.
    p0 = n_pops;
    send_frame(8'h5A, 1'b0, 1'b1);
    idle(1);
    send_frame(8'h81, 1'b0, 1'b0);
    idle(12);
    drain("t3");
    check("t3_frame_err_cnt", act_ferr, 1);
    check("t3_beats", n_pops - p0, 1);
    check("t3_data", last_pop_data, 8'h81);
    check_errs("t3");

    // 4: short glitch is a false start; next frame still received.
    p0 = n_pops;
    rx = 1'b0;
    repeat (6) tick();
    rx = 1'b1;
    idle(2);
    check("t4_beats", n_pops - p0, 0);
    check_errs("t4");
    send_frame(8'h96, 1'b0, 1'b0);
    idle(12);
    drain("t4b");
    check("t4b_data", last_pop_data, 8'h96);

    // 5: fill with tready low, overrun on the 17th byte, then drain in order.
    m_axis_tready = 1'b0;
    p0 = n_pops;
    for (int i = 0; i <= 16; i++) begin
      send_frame(8'(i), 1'b0, 1'b0);
      idle(1);
    end
    idle(12);
    check("t5_level_full", fifo_level, 16);
    check("t5_level_model", fifo_level, model_level);
    check("t5_overrun_cnt", act_ovr, 1);
    m_axis_tready = 1'b1;
    drain("t5");
    check("t5_beats", n_pops - p0, 16);
    check("t5_last_data", last_pop_data, 8'h0F);
    check_errs("t5");

`ifdef UART_RX_IDLE_TLAST_EN
    // 6a: burst of three; only the final byte carries tlast.
    send_frame(8'h01, 1'b0, 1'b0);
    idle(1);
    send_frame(8'h02, 1'b0, 1'b0);
    idle(1);
    send_frame(8'h03, 1'b0, 1'b0);
    idle(12);
    drain("t6a");
    check("t6a_beat0", hist[hist.size() - 3], {1'b0, 8'h01});
    check("t6a_beat1", hist[hist.size() - 2], {1'b0, 8'h02});
    check("t6a_beat2", hist[hist.size() - 1], {1'b1, 8'h03});
`endif

    // 6b: reset in the middle of a frame flushes everything.
    m_axis_tready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0);
    idle(1);
    send_frame(8'h22, 1'b0, 1'b0);
    idle(1);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    rx  = 1'b1;
    rst = 1'b1;
    exp_q.delete();
    model_level = 0;
    pending = 1'b0;
    repeat (3) tick();
    check("t6_rst_level", fifo_level, 0);
    check("t6_rst_tvalid", m_axis_tvalid, 1'b0);
    rst = 1'b0;
    p0 = n_pops;
    m_axis_tready = 1'b1;
    idle(14);
    check("t6_post_beats", n_pops - p0, 0);
    check("t6_post_level", fifo_level, 0);
    send_frame(8'h44, 1'b0, 1'b0);
    idle(12);
    drain("t6");
    check("t6_recover_data", last_pop_data, 8'h44);
    check_errs("t6");

    // Randomized frames, errors and back-pressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      send_frame(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
      idle(($urandom_range(0, 3) == 0) ? 12 : 1);
    end
    rand_ready = 1'b0;
    m_axis_tready = 1'b1;
    idle(12);
    drain("rand");
    check_errs("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
